// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//   Shared definitions for the CORDIC arbiter slice: controller state
//   encoding, default sizing parameters and a small helper that sizes
//   requester index fields.
//
//   Contents:
//     CORDIC_ITERS  iteration count of the attached CORDIC core
//     NREQ_DEF      default number of requesters
//     DW_DEF        default operand/result width
//     TMO_DEF       default watchdog limit (iterations plus margin)
//     arb_state_e   controller states IDLE/START/BUSY/RESP
//     idx_width()   bits needed to hold a requester index (min 1)
// ---------------------------------------------------------------------------
package cordic_pkg;

  localparam int CORDIC_ITERS = 16;
  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 16;

  // Twice the iteration count leaves room for core pipeline overhead
  // without letting a hung core stall the requesters for long.
  localparam int TMO_DEF      = 2 * CORDIC_ITERS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_BUSY  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_e;

  // A single requester still needs a one-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin selector. Starting one position after
//   the last winner (ptr) it searches upward, wrapping modulo NREQ, and
//   reports the first requester whose req bit is set.
//
//   Ports:
//     req      in   NREQ  request levels
//     ptr      in   IW    index of the previous winner
//     win_oh   out  NREQ  one-hot winner (all zero when no request)
//     win_idx  out  IW    binary index of the winner
//     win_vld  out  1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import cordic_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  logic [IW-1:0] cand;

  // Offsets 1..NREQ visit every requester exactly once, with the previous
  // winner (offset NREQ) checked last so it cannot starve the others.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld       = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter
//   Shares one iterative CORDIC core between NREQ requesters. A round-robin
//   winner's angle operand is captured and handed to the core, the core's
//   completion strobe is awaited under a watchdog, and the x/y result (or an
//   abort indication) is returned to the owning requester over valid/ready.
//
//   Ports:
//     clk       in   1        system clock, rising edge
//     rst_n     in   1        asynchronous active-low reset
//     req       in   NREQ     per-requester request level
//     arg       in   NREQ*DW  per-requester operand, slice i = arg[i*DW +: DW]
//     gnt       out  NREQ     one-hot one-cycle pulse: operand captured
//     rsp_vld   out  NREQ     one-hot: response available for that requester
//     rsp_rdy   in   NREQ     per-requester response accept
//     rsp_x     out  DW       result x, qualified by rsp_vld
//     rsp_y     out  DW       result y, qualified by rsp_vld
//     rsp_err   out  1        response is a watchdog abort
//     busy      out  1        controller is not idle
//     core_bgn  out  1        start pulse to the CORDIC core
//     core_z    out  DW       operand to the core
//     core_fin  in   1        core completion strobe
//     core_x    in   DW       core x result
//     core_y    in   DW       core y result
// ---------------------------------------------------------------------------
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] arg,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_vld,
  input  logic [NREQ-1:0]   rsp_rdy,
  output logic [DW-1:0]     rsp_x,
  output logic [DW-1:0]     rsp_y,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_bgn,
  output logic [DW-1:0]     core_z,
  input  logic              core_fin,
  input  logic [DW-1:0]     core_x,
  input  logic [DW-1:0]     core_y
);

  localparam int IW = idx_width(NREQ);
  localparam int WW = $clog2(TMO) + 1;
  localparam logic [WW-1:0] WDG_LAST = WW'(TMO - 1);
  localparam logic [WW-1:0] WDG_MAX  = '1;

  arb_state_e      state_q,    state_d;
  logic [NREQ-1:0] gnt_q,      gnt_d;
  logic            core_bgn_q, core_bgn_d;
  logic [NREQ-1:0] rsp_vld_q,  rsp_vld_d;
  logic [DW-1:0]   rsp_x_q,    rsp_x_d;
  logic [DW-1:0]   rsp_y_q,    rsp_y_d;
  logic            rsp_err_q,  rsp_err_d;
  logic [DW-1:0]   core_z_q,   core_z_d;
  logic [IW-1:0]   owner_q,    owner_d;
  logic [IW-1:0]   ptr_q,      ptr_d;
  logic [WW-1:0]   wdg_q,      wdg_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // Next-state and next-output decode for the controller.
  // The start pulse is registered while in START, so it appears on the
  // first BUSY cycle, one cycle after the grant pulse. The watchdog is
  // cleared in START and only advances while waiting in BUSY.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    core_bgn_d = 1'b0;
    rsp_vld_d  = rsp_vld_q;
    rsp_x_d    = rsp_x_q;
    rsp_y_d    = rsp_y_q;
    rsp_err_d  = rsp_err_q;
    core_z_d   = core_z_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    wdg_d      = wdg_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick_oh;
          core_z_d = arg[int'(pick_idx)*DW +: DW];
          owner_d  = pick_idx;
          ptr_d    = pick_idx;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        core_bgn_d = 1'b1;
        wdg_d      = '0;
        state_d    = ST_BUSY;
      end

      ST_BUSY: begin
        // A completion in the expiry cycle still counts as a normal result.
        if (core_fin) begin
          rsp_x_d            = core_x;
          rsp_y_d            = core_y;
          rsp_err_d          = 1'b0;
          rsp_vld_d          = '0;
          rsp_vld_d[owner_q] = 1'b1;
          state_d            = ST_RESP;
        end else if (wdg_q >= WDG_LAST) begin
          rsp_x_d            = '0;
          rsp_y_d            = '0;
          rsp_err_d          = 1'b1;
          rsp_vld_d          = '0;
          rsp_vld_d[owner_q] = 1'b1;
          state_d            = ST_RESP;
        end else if (wdg_q != WDG_MAX) begin
          wdg_d = wdg_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Only the owner's ready can retire the response.
        if (rsp_rdy[owner_q]) begin
          rsp_vld_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset leaves the pointer on the last
  // requester so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      core_bgn_q <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_x_q    <= '0;
      rsp_y_q    <= '0;
      rsp_err_q  <= 1'b0;
      core_z_q   <= '0;
      owner_q    <= '0;
      ptr_q      <= IW'(NREQ - 1);
      wdg_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      core_bgn_q <= core_bgn_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_x_q    <= rsp_x_d;
      rsp_y_q    <= rsp_y_d;
      rsp_err_q  <= rsp_err_d;
      core_z_q   <= core_z_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      wdg_q      <= wdg_d;
    end
  end

  assign gnt      = gnt_q;
  assign core_bgn = core_bgn_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_x    = rsp_x_q;
  assign rsp_y    = rsp_y_q;
  assign rsp_err  = rsp_err_q;
  assign core_z   = core_z_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cordic_arbiter
//   Scoreboard bench for cordic_arbiter. The stimulus side plays both the
//   requesters and the CORDIC core, predicts the grant order from the
//   round-robin rule and pushes expected grants/responses into queues; an
//   independent monitor pops and compares whenever the DUT shows a grant or
//   a new response.
// ---------------------------------------------------------------------------
module tb_cordic_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int TMO  = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   arg;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_vld;
   logic [NREQ-1:0]      rsp_rdy;
   logic [DW-1:0]        rsp_x;
   logic [DW-1:0]        rsp_y;
   logic                 rsp_err;
   logic                 busy;
   logic                 core_bgn;
   logic [DW-1:0]        core_z;
   logic                 core_fin;
   logic [DW-1:0]        core_x;
   logic [DW-1:0]        core_y;

   typedef struct {
      int            owner;
      logic [DW-1:0] z;
   } gntExp_t;

   typedef struct {
      int            owner;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic          err;
   } rspExp_t;

   gntExp_t       gntQ[$];
   rspExp_t       rspQ[$];
   gntExp_t       monG;
   rspExp_t       monR;
   int            checks = 0;
   int            errors = 0;
   int            lastWinner = NREQ - 1;
   logic [DW-1:0] argArr [NREQ];
   logic          rspSeen = 1'b0;

   cordic_arbiter #(
      .NREQ (NREQ),
      .DW   (DW),
      .TMO  (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .arg      (arg),
      .gnt      (gnt),
      .rsp_vld  (rsp_vld),
      .rsp_rdy  (rsp_rdy),
      .rsp_x    (rsp_x),
      .rsp_y    (rsp_y),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .core_bgn (core_bgn),
      .core_z   (core_z),
      .core_fin (core_fin),
      .core_x   (core_x),
      .core_y   (core_y)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Round-robin reference: search upward from the requester after the
   // previous winner, wrapping around the requester ring.
   function automatic int modelPick(input logic [NREQ-1:0] mask);
      for (int k = 1; k <= NREQ; k++) begin
         if (mask[(lastWinner + k) % NREQ]) return (lastWinner + k) % NREQ;
      end
      return -1;
   endfunction

   // Monitor: every grant pulse and every newly presented response is
   // matched against the oldest entry of the corresponding queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt != '0) begin
            if (gntQ.size() == 0) begin
               checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
               monG = gntQ.pop_front();
               checkOutput("gnt_onehot", 32'(gnt), 32'(1) << monG.owner);
               checkOutput("gnt_core_z", 32'(core_z), 32'(monG.z));
            end
         end
         if (rsp_vld != '0 && !rspSeen) begin
            rspSeen = 1'b1;
            if (rspQ.size() == 0) begin
               checkOutput("unexpected_rsp", 32'(rsp_vld), 32'd0);
            end else begin
               monR = rspQ.pop_front();
               checkOutput("rsp_vld_onehot", 32'(rsp_vld), 32'(1) << monR.owner);
               checkOutput("rsp_x", 32'(rsp_x), 32'(monR.x));
               checkOutput("rsp_y", 32'(rsp_y), 32'(monR.y));
               checkOutput("rsp_err", 32'(rsp_err), 32'(monR.err));
            end
         end
         if (rsp_vld == '0) rspSeen = 1'b0;
      end else begin
         rspSeen = 1'b0;
      end
   end

   // One complete transaction. finDelay < 0 means the core never finishes;
   // rdyHold is the number of cycles the owner withholds rsp_rdy.
   task automatic applyStimulus(input logic [NREQ-1:0] mask, input int finDelay,
                                input int rdyHold, input logic useDir,
                                input logic [DW-1:0] dirArg, input logic [DW-1:0] dirX,
                                input logic [DW-1:0] dirY);
      int              w;
      int              cyc;
      int              expLat;
      int              good;
      logic [DW-1:0]   ex;
      logic [DW-1:0]   ey;
      logic [NREQ-1:0] ownerBit;
      gntExp_t         ge;
      rspExp_t         re;

      for (int i = 0; i < NREQ; i++) begin
         argArr[i] = useDir ? dirArg : DW'($urandom);
         arg[i*DW +: DW] = argArr[i];
      end
      w = modelPick(mask);
      lastWinner = w;
      ge.owner = w;
      ge.z     = argArr[w];
      gntQ.push_back(ge);
      req = mask;

      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (gnt == '0 && cyc < 8);
      checkOutput("gnt_latency", cyc, 1);
      req = '0;

      @(negedge clk);
      checkOutput("core_bgn", 32'(core_bgn), 32'd1);
      checkOutput("busy_in_op", 32'(busy), 32'd1);

      ex = useDir ? dirX : DW'($urandom);
      ey = useDir ? dirY : DW'($urandom);
      re.owner = w;
      re.x     = (finDelay >= 0) ? ex : '0;
      re.y     = (finDelay >= 0) ? ey : '0;
      re.err   = (finDelay < 0);
      rspQ.push_back(re);
      expLat = (finDelay >= 0) ? finDelay + 1 : TMO;

      cyc = 0;
      while (rsp_vld == '0 && cyc < TMO + 8) begin
         core_fin = (cyc == finDelay);
         core_x   = core_fin ? ex : DW'($urandom);
         core_y   = core_fin ? ey : DW'($urandom);
         @(negedge clk);
         cyc++;
      end
      core_fin = 1'b0;
      checkOutput("rsp_latency", cyc, expLat);

      // Backpressure: other requesters' ready bits and fresh requests
      // must neither retire the response nor cause a grant.
      ownerBit = NREQ'(1) << w;
      good = 0;
      for (int k = 0; k < rdyHold; k++) begin
         rsp_rdy = NREQ'($urandom) & ~ownerBit;
         req     = NREQ'($urandom);
         @(negedge clk);
         if (rsp_vld == ownerBit && rsp_x == re.x && rsp_y == re.y &&
             rsp_err == re.err && gnt == '0) good++;
      end
      if (rdyHold > 0) checkOutput("rsp_hold", good, rdyHold);

      rsp_rdy = ownerBit | NREQ'($urandom);
      @(negedge clk);
      rsp_rdy = '0;
      req     = '0;
      checkOutput("rsp_release", 32'(rsp_vld), 32'd0);
      checkOutput("idle_after_rsp", 32'(busy), 32'd0);
   endtask

   // A core strobe while idle must not create a response.
   task automatic strayFin();
      int bad;
      bad = 0;
      core_fin = 1'b1;
      core_x   = DW'($urandom);
      core_y   = DW'($urandom);
      @(negedge clk);
      core_fin = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rsp_vld != '0 || busy) bad++;
      end
      checkOutput("stray_fin_ignored", bad, 0);
   endtask

   // Asynchronous reset in the middle of a core operation.
   task automatic resetMidBusy();
      gntExp_t ge;
      for (int i = 0; i < NREQ; i++) begin
         argArr[i] = DW'($urandom);
         arg[i*DW +: DW] = argArr[i];
      end
      lastWinner = modelPick(4'b0010);
      ge.owner = lastWinner;
      ge.z     = argArr[lastWinner];
      gntQ.push_back(ge);
      req = 4'b0010;
      @(negedge clk);
      req = '0;
      repeat (6) @(negedge clk);
      checkOutput("busy_before_reset", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_core_z", 32'(core_z), 32'd0);
      lastWinner = NREQ - 1;
      core_fin = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      core_fin = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("no_rsp_after_reset", 32'(rsp_vld), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int finDelay;
      rst_n    = 1'b0;
      req      = '0;
      arg      = '0;
      rsp_rdy  = '0;
      core_fin = 1'b0;
      core_x   = '0;
      core_y   = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_gnt", 32'(gnt), 32'd0);
      checkOutput("reset_rsp_vld", 32'(rsp_vld), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_rsp_x", 32'(rsp_x), 32'd0);
      checkOutput("reset_rsp_y", 32'(rsp_y), 32'd0);
      checkOutput("reset_core_z", 32'(core_z), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_core_bgn", 32'(core_bgn), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single request");
      applyStimulus(4'b0001, 15, 0, 1'b1, 16'h2000, 16'h1234, 16'h0567);

      $display("[TB] round robin");
      for (int t = 0; t < 4; t++)
         applyStimulus(4'b1111, $urandom_range(0, 20), 0, 1'b0, '0, '0, '0);
      for (int t = 0; t < 3; t++)
         applyStimulus(4'b1010, $urandom_range(0, 20), 0, 1'b0, '0, '0, '0);

      $display("[TB] backpressure");
      applyStimulus(4'b0110, 5, 10, 1'b0, '0, '0, '0);

      $display("[TB] watchdog abort");
      applyStimulus(4'b1000, -1, 2, 1'b0, '0, '0, '0);
      strayFin();

      $display("[TB] completion at watchdog expiry");
      applyStimulus(4'b0101, TMO - 1, 1, 1'b0, '0, '0, '0);

      $display("[TB] withdrawn request");
      req = 4'b0100;
      #1 req = '0;
      repeat (2) @(negedge clk);
      checkOutput("withdraw_no_gnt", 32'(gnt), 32'd0);

      $display("[TB] reset during busy");
      resetMidBusy();
      applyStimulus(4'b0100, 3, 0, 1'b0, '0, '0, '0);

      $display("[TB] random traffic");
      for (int t = 0; t < 20; t++) begin
         finDelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
         applyStimulus(NREQ'($urandom_range(1, 15)), finDelay,
                       $urandom_range(0, 3), 1'b0, '0, '0, '0);
      end

      repeat (2) @(negedge clk);
      checkOutput("gnt_queue_drained", gntQ.size(), 0);
      checkOutput("rsp_queue_drained", rspQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
